seed_loader: RTL and testbench

- Writer side of the cell array's init/rst interface: accepts a serial seed pattern over a valid/ready stream and assembles it into a per-cell init vector.
- Then issues a one-cycle reset pulse to the whole cell array, so every cell re-samples its init bit and starts the game from the loaded pattern.
- Sits between the host/pattern source and the cell grid top level.

---
 rtl/gol_pkg.sv | 15 +
 rtl/seed_loader_if.sv | 24 ++
 rtl/seed_loader.sv | 105 ++++++++++
 tb/tb_seed_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Types and defaults shared between the seed loader and the cell grid top level.
package gol_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        CELL_RST = 3'd2,
        SETTLE   = 3'd3,
        DONE     = 3'd4
    } load_state_t;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

endpackage

// File: rtl/seed_loader_if.sv
// Pattern-load interface: host-side seed stream in, per-cell init vector and grid reset out.
interface seed_loader_if #(
    parameter int N = 64
) ();
    logic         load_start;
    logic         load_abort;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [N-1:0] init_vec;
    logic         cell_rst;
    logic         busy;
    logic         done;

    modport master (
        output load_start, load_abort, bit_in, bit_valid,
        input  bit_ready, init_vec, cell_rst, busy, done
    );

    modport slave (
        input  load_start, load_abort, bit_in, bit_valid,
        output bit_ready, init_vec, cell_rst, busy, done
    );
endinterface

// File: rtl/seed_loader.sv
// Assembles a serial row-major seed into the grid's init vector, then pulses the
// cell reset once so every cell starts from the new pattern.
//
// state    | meaning
// IDLE     | waiting for load_start
// SHIFT    | accepting seed bits into the shadow register
// CELL_RST | one-cycle reset pulse to all cells
// SETTLE   | cells sample init_vec at the end of this cycle
// DONE     | one-cycle completion pulse
module seed_loader
    import gol_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic         clk,
    input  logic         rst,
    seed_loader_if.slave bus
);
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    load_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic [N-1:0]  init_vec_q, init_vec_d;
    logic          bit_ready_q, bit_ready_d;
    logic          cell_rst_q, cell_rst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        init_vec_d = init_vec_q;

        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d  = SHIFT;
                    count_d  = '0;
                    shadow_d = '0;
                end
            end
            SHIFT: begin
                // Abort takes priority even over the final transfer, so a
                // half-loaded pattern can never reach the cells.
                if (bus.load_abort) begin
                    state_d = IDLE;
                end else if (bus.bit_valid) begin
                    if (count_q == LAST) begin
                        init_vec_d = {bus.bit_in, shadow_q[N-2:0]};
                        state_d    = CELL_RST;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (CW'(i) == count_q) shadow_d[i] = bus.bit_in;
                        end
                        count_d = count_q + 1'b1;
                    end
                end
            end
            CELL_RST: state_d = SETTLE;
            SETTLE:   state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Moore outputs registered from the next state so they align with it.
        bit_ready_d = (state_d == SHIFT);
        cell_rst_d  = (state_d == CELL_RST);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shadow_q    <= '0;
            init_vec_q  <= '0;
            bit_ready_q <= 1'b0;
            cell_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shadow_q    <= shadow_d;
            init_vec_q  <= init_vec_d;
            bit_ready_q <= bit_ready_d;
            cell_rst_q  <= cell_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.bit_ready = bit_ready_q;
    assign bus.init_vec  = init_vec_q;
    assign bus.cell_rst  = cell_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seed_loader.sv
// Directed test of the seed loader on a 3x3 grid.
module tb_seed_loader;
    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    seed_loader_if #(.N(N)) bus ();

    seed_loader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full load of pat with bit_valid held high, checking the output timeline.
    task automatic do_load(input logic [8:0] pat, input string tag);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL %s busy after start: got %b want 1", tag, bus.busy); end
        for (int i = 0; i < 9; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = pat[i];
            tick();
            if (i < 8) begin
                n_cmp++; if (bus.cell_rst !== 1'b0 || bus.bit_ready !== 1'b1) begin
                    n_bad++; $display("FAIL %s shift bit %0d: cell_rst=%b bit_ready=%b want 0/1", tag, i, bus.cell_rst, bus.bit_ready);
                end
            end
        end
        bus.bit_valid = 1'b0;
        n_cmp++; if (bus.cell_rst !== 1'b1) begin n_bad++; $display("FAIL %s cell_rst at E: got %b want 1", tag, bus.cell_rst); end
        n_cmp++; if (bus.init_vec !== pat) begin n_bad++; $display("FAIL %s init_vec: got %h want %h", tag, bus.init_vec, pat); end
        n_cmp++; if (bus.bit_ready !== 1'b0) begin n_bad++; $display("FAIL %s bit_ready at E: got %b want 0", tag, bus.bit_ready); end
        tick();
        n_cmp++; if (bus.cell_rst !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL %s settle: cell_rst=%b done=%b busy=%b want 0/0/1", tag, bus.cell_rst, bus.done, bus.busy);
        end
        tick();
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL %s done at E+2: got %b want 1", tag, bus.done); end
        tick();
        n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL %s end: done=%b busy=%b want 0/0", tag, bus.done, bus.busy);
        end
        n_cmp++; if (bus.init_vec !== pat) begin n_bad++; $display("FAIL %s init_vec held: got %h want %h", tag, bus.init_vec, pat); end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.busy !== 1'b0 || bus.bit_ready !== 1'b0 || bus.cell_rst !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL reset outputs: busy=%b ready=%b cell_rst=%b done=%b want 0", bus.busy, bus.bit_ready, bus.cell_rst, bus.done);
        end
        n_cmp++; if (bus.init_vec !== 9'h000) begin n_bad++; $display("FAIL reset init_vec: got %h want 000", bus.init_vec); end
        tick();
        rst = 1'b0;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick(); tick();
        bus.bit_valid = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.bit_ready !== 1'b0 || bus.init_vec !== 9'h000) begin
            n_bad++; $display("FAIL idle valid ignored: busy=%b ready=%b init=%h want 0/0/000", bus.busy, bus.bit_ready, bus.init_vec);
        end
        // start and abort together in IDLE: start wins
        bus.load_start = 1'b1;
        bus.load_abort = 1'b1;
        tick();
        bus.load_start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1 || bus.bit_ready !== 1'b1) begin
            n_bad++; $display("FAIL start_vs_abort: busy=%b ready=%b want 1/1", bus.busy, bus.bit_ready);
        end
        tick();
        bus.load_abort = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort from shift: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_blinker();
        do_load(9'h092, "blinker");
    endtask

    task automatic test_toggle_valid();
        logic [8:0] pat = 9'h092;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            bus.bit_valid = (k % 2 == 0);
            bus.bit_in    = (k % 2 == 0) ? pat[k/2] : ~pat[k/2];
            tick();
            if (k < 16) begin
                n_cmp++; if (bus.bit_ready !== 1'b1 || bus.cell_rst !== 1'b0) begin
                    n_bad++; $display("FAIL toggle k=%0d: ready=%b cell_rst=%b want 1/0", k, bus.bit_ready, bus.cell_rst);
                end
            end
        end
        bus.bit_valid = 1'b0;
        n_cmp++; if (bus.cell_rst !== 1'b1 || bus.init_vec !== 9'h092) begin
            n_bad++; $display("FAIL toggle complete: cell_rst=%b init=%h want 1/092", bus.cell_rst, bus.init_vec);
        end
        tick(); tick(); tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL toggle drain: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_abort();
        do_load(9'h1FF, "ones");
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b0;
            tick();
            n_cmp++; if (bus.cell_rst !== 1'b0) begin n_bad++; $display("FAIL abort shift cell_rst: got %b want 0", bus.cell_rst); end
        end
        bus.load_abort = 1'b1;
        tick();
        bus.load_abort = 1'b0;
        bus.bit_valid  = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.cell_rst !== 1'b0 || bus.bit_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort: busy=%b cell_rst=%b ready=%b want 0/0/0", bus.busy, bus.cell_rst, bus.bit_ready);
        end
        n_cmp++; if (bus.init_vec !== 9'h1FF) begin n_bad++; $display("FAIL abort init_vec: got %h want 1FF", bus.init_vec); end
        tick(); tick();
        n_cmp++; if (bus.cell_rst !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL abort after: cell_rst=%b done=%b want 0/0", bus.cell_rst, bus.done);
        end
    endtask

    task automatic test_start_ignored();
        logic [8:0] pat = 9'h0A5;
        int dones = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.bit_valid  = 1'b1;
            bus.bit_in     = pat[i];
            bus.load_start = (i == 4);
            tick();
        end
        bus.bit_valid  = 1'b0;
        n_cmp++; if (bus.cell_rst !== 1'b1 || bus.init_vec !== pat) begin
            n_bad++; $display("FAIL start in shift: cell_rst=%b init=%h want 1/0a5", bus.cell_rst, bus.init_vec);
        end
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        n_cmp++; if (bus.cell_rst !== 1'b0 || bus.busy !== 1'b1 || bus.bit_ready !== 1'b0) begin
            n_bad++; $display("FAIL start in cell_rst: cell_rst=%b busy=%b ready=%b want 0/1/0", bus.cell_rst, bus.busy, bus.bit_ready);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL done count: got %0d want 1", dones); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL start ignored end busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_async_rst();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            tick();
        end
        bus.bit_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.bit_ready !== 1'b0 || bus.cell_rst !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL async rst outputs: busy=%b ready=%b cell_rst=%b done=%b want 0", bus.busy, bus.bit_ready, bus.cell_rst, bus.done);
        end
        n_cmp++; if (bus.init_vec !== 9'h000) begin n_bad++; $display("FAIL async rst init_vec: got %h want 000", bus.init_vec); end
        #1 rst = 1'b0;
        tick();
        do_load(9'h092, "post_rst");
    endtask

    task automatic test_abort_final();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.bit_valid  = 1'b1;
            bus.bit_in     = 1'b1;
            bus.load_abort = (i == 8);
            tick();
        end
        bus.bit_valid  = 1'b0;
        bus.load_abort = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.cell_rst !== 1'b0 || bus.bit_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort final: busy=%b cell_rst=%b ready=%b want 0/0/0", bus.busy, bus.cell_rst, bus.bit_ready);
        end
        n_cmp++; if (bus.init_vec !== 9'h092) begin n_bad++; $display("FAIL abort final init_vec: got %h want 092", bus.init_vec); end
        tick(); tick();
        n_cmp++; if (bus.cell_rst !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL abort final after: cell_rst=%b done=%b want 0/0", bus.cell_rst, bus.done);
        end
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_abort = 1'b0;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        test_reset();
        test_blinker();
        test_toggle_valid();
        test_abort();
        test_start_ignored();
        test_async_rst();
        test_abort_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
